// File: rtl/uart_encoder.sv
// uart_encoder: 8N1 UART transmitter fed by a small valid/ready FIFO.
// Each byte is sent as one start bit, eight data bits LSB first and one
// stop bit; every bit lasts i_Period+1 clocks, sampled once per frame.
module uart_encoder #(
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic                       i_Clk,
    input  logic                       i_Rst_L,
    input  logic [19:0]                i_Period,
    input  logic [7:0]                 i_Byte,
    input  logic                       i_Valid,
    output logic                       o_Ready,
    output logic                       o_UART_TX,
    output logic                       o_Busy,
    output logic                       o_Done,
    output logic [FIFO_DEPTH_LOG2:0]   o_Fifo_Count,
    output logic [2:0]                 o_Encoder_State
);

    localparam int                     DEPTH      = 1 << FIFO_DEPTH_LOG2;
    localparam logic [FIFO_DEPTH_LOG2:0] FULL_COUNT = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;

    logic [7:0]                 r_Mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] r_Wr_Ptr;
    logic [FIFO_DEPTH_LOG2-1:0] r_Rd_Ptr;
    logic [FIFO_DEPTH_LOG2:0]   r_Count;

    logic [2:0]  r_State;
    logic [19:0] r_Bit_Cnt;
    logic [19:0] r_Period;
    logic [2:0]  r_Bit_Idx;
    logic [7:0]  r_Shift;
    logic        r_Tx;

    logic w_Push;
    logic w_Pop;
    logic w_Not_Empty;
    logic w_Bit_End;

    assign w_Not_Empty = (r_Count != '0);
    assign w_Bit_End   = (r_Bit_Cnt == r_Period);
    assign o_Ready     = (r_Count != FULL_COUNT);
    assign w_Push      = i_Valid && o_Ready;
    // The head leaves the FIFO when a frame starts: from IDLE, or straight
    // out of the last stop-bit cycle so consecutive frames have no gap.
    assign w_Pop       = w_Not_Empty &&
                         ((r_State == IDLE) || ((r_State == STOP) && w_Bit_End));

    assign o_UART_TX       = r_Tx;
    assign o_Busy          = (r_State != IDLE);
    assign o_Done          = (r_State == STOP) && w_Bit_End;
    assign o_Fifo_Count    = r_Count;
    assign o_Encoder_State = r_State;

    // FIFO storage write; contents are plain data and need no reset.
    always_ff @(posedge i_Clk) begin
        if (w_Push) begin
            r_Mem[r_Wr_Ptr] <= i_Byte;
        end
    end

    // FIFO pointers and occupancy; push and pop together leave count unchanged.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_Wr_Ptr <= '0;
            r_Rd_Ptr <= '0;
            r_Count  <= '0;
        end else begin
            if (w_Push) begin
                r_Wr_Ptr <= r_Wr_Ptr + 1'b1;
            end
            if (w_Pop) begin
                r_Rd_Ptr <= r_Rd_Ptr + 1'b1;
            end
            case ({w_Push, w_Pop})
                2'b10:   r_Count <= r_Count + 1'b1;
                2'b01:   r_Count <= r_Count - 1'b1;
                default: r_Count <= r_Count;
            endcase
        end
    end

    // Shift register captures the FIFO head on every pop.
    always_ff @(posedge i_Clk) begin
        if (w_Pop) begin
            r_Shift <= r_Mem[r_Rd_Ptr];
        end
    end

    // Frame sequencer: drives the registered line and times each bit.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_State   <= IDLE;
            r_Tx      <= 1'b1;
            r_Bit_Cnt <= '0;
            r_Period  <= '0;
            r_Bit_Idx <= '0;
        end else begin
            case (r_State)
                IDLE: begin
                    r_Tx      <= 1'b1;
                    r_Bit_Cnt <= '0;
                    r_Bit_Idx <= '0;
                    if (w_Not_Empty) begin
                        r_Period <= i_Period;
                        r_State  <= START;
                        r_Tx     <= 1'b0;
                    end
                end
                START: begin
                    if (w_Bit_End) begin
                        r_Bit_Cnt <= '0;
                        r_Bit_Idx <= '0;
                        r_State   <= DATA;
                        r_Tx      <= r_Shift[0];
                    end else begin
                        r_Bit_Cnt <= r_Bit_Cnt + 20'd1;
                    end
                end
                DATA: begin
                    if (w_Bit_End) begin
                        r_Bit_Cnt <= '0;
                        if (r_Bit_Idx == 3'd7) begin
                            r_State <= STOP;
                            r_Tx    <= 1'b1;
                        end else begin
                            r_Bit_Idx <= r_Bit_Idx + 3'd1;
                            r_Tx      <= r_Shift[r_Bit_Idx + 3'd1];
                        end
                    end else begin
                        r_Bit_Cnt <= r_Bit_Cnt + 20'd1;
                    end
                end
                STOP: begin
                    if (w_Bit_End) begin
                        r_Bit_Cnt <= '0;
                        r_Bit_Idx <= '0;
                        if (w_Not_Empty) begin
                            r_Period <= i_Period;
                            r_State  <= START;
                            r_Tx     <= 1'b0;
                        end else begin
                            r_State <= IDLE;
                            r_Tx    <= 1'b1;
                        end
                    end else begin
                        r_Bit_Cnt <= r_Bit_Cnt + 20'd1;
                    end
                end
                default: begin
                    r_State   <= IDLE;
                    r_Tx      <= 1'b1;
                    r_Bit_Cnt <= '0;
                    r_Bit_Idx <= '0;
                end
            endcase
        end
    end

endmodule
